// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter for fetch and LSU with an owner-tag pipeline for read returns.
// Define ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_flush,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic              rst_hold_q, rst_hold_d;
  logic              quiet;
  logic              f_elig, d_elig;
  logic              f_win, d_win;
  logic              new_vld, new_own;
  logic [RD_LAT-1:0] src_vld, src_own;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_own_q, tag_own_d;

  // Outputs stay silent during reset and for one cycle after it.
  assign quiet  = rst | rst_hold_q;
  assign f_elig = f_req & ~c_flush & ~quiet;
  assign d_elig = d_req & ~quiet;

`ifdef ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    f_win  = f_elig;
    d_win  = d_elig;
    last_d = last_q;
    if (f_elig && d_elig) begin
      f_win = (last_q == OWN_D);
      d_win = (last_q == OWN_F);
    end
    if (f_win) begin
      last_d = OWN_F;
    end else if (d_win) begin
      last_d = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_D;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    d_win = d_elig;
    f_win = f_elig & ~d_elig;
  end
`endif

  assign f_gnt = f_win;
  assign d_gnt = d_win;

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (d_win) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (f_win) begin
      m_en   = 1'b1;
      m_addr = f_addr;
    end
  end

  // Only reads carry a tag; writes complete in their grant cycle.
  assign new_vld = (d_win & ~d_we) | f_win;
  assign new_own = d_win ? OWN_D : OWN_F;

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign src_vld[gi] = new_vld;
        assign src_own[gi] = new_own;
      end else begin : g_body
        assign src_vld[gi] = tag_vld_q[gi-1];
        assign src_own[gi] = tag_own_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    rst_hold_d = rst;
    tag_own_d  = src_own;
    for (int i = 0; i < RD_LAT; i++) begin
      tag_vld_d[i] = src_vld[i] & ~(c_flush & (src_own[i] == OWN_F));
    end
  end

  always_ff @(posedge clk) begin
    rst_hold_q <= rst_hold_d;
    if (rst) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  // Retiring tag steers the shared read data; a flush suppresses a retiring fetch.
  always_comb begin
    f_rvalid = 1'b0;
    d_rvalid = 1'b0;
    f_rdata  = '0;
    d_rdata  = '0;
    if (!quiet) begin
      f_rdata = m_rdata;
      d_rdata = m_rdata;
      if (tag_vld_q[RD_LAT-1]) begin
        if (tag_own_q[RD_LAT-1] == OWN_F) begin
          f_rvalid = ~c_flush;
        end else begin
          d_rvalid = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 and RD_LAT=2 instances on shared stimulus,
// checked against a due-cycle return schedule and a golden memory image.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst, c_flush, f_req, d_req, d_we, init_mem;
  logic [31:0] f_addr, d_addr, d_wdata;

  logic        f_gnt1, f_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1;
  logic [31:0] f_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic        f_gnt2, f_rvalid2, d_gnt2, d_rvalid2, m_en2, m_we2;
  logic [31:0] f_rdata2, d_rdata2, m_addr2, m_wdata2, m_rdata2;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .c_flush(c_flush),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt1), .f_rvalid(f_rvalid1), .f_rdata(f_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .c_flush(c_flush),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt2), .f_rvalid(f_rvalid2), .f_rdata(f_rdata2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .m_en(m_en2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_rdata(m_rdata2)
  );

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] a;
    a = i[7:0];
    if (i == 'h10) return 32'hDEADBEEF;
    return {a, 8'h5A, ~a, 8'hC3};
  endfunction

  // BRAM models: 256 words, registered read, latency 1 and 2.
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] rd1_q, rd2_a, rd2_b;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_val(i);
    end else if (m_en1) begin
      if (m_we1) mem1[m_addr1[7:0]] <= m_wdata1;
      rd1_q <= mem1[m_addr1[7:0]];
    end
  end
  assign m_rdata1 = rd1_q;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem2[i] <= init_val(i);
    end else if (m_en2) begin
      if (m_we2) mem2[m_addr2[7:0]] <= m_wdata2;
      rd2_a <= mem2[m_addr2[7:0]];
    end
    rd2_b <= rd2_a;
  end
  assign m_rdata2 = rd2_b;

  // Reference model: pending returns indexed by due cycle (mod 8), per latency.
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] gold [256];
  bit          pv [2][8];
  bit          po [2][8];
  logic [31:0] pd [2][8];
  bit          last_lsu = 1'b1;
  bit          rst_prev = 1'b1;
  bit          last_fg, last_dg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input string p, input logic fgn, input logic dgn, input logic men,
                           input logic mwe, input logic [31:0] madr, input logic [31:0] mwd,
                           input logic frv, input logic drv, input logic [31:0] frd,
                           input logic [31:0] drd, input bit efg, input bit edg,
                           input logic [31:0] ea, input logic [31:0] ew, input bit ewe,
                           input bit efr, input bit edr, input logic [31:0] edat, input bit quiet);
    chk({p, "_f_gnt"}, {31'd0, fgn}, {31'd0, efg});
    chk({p, "_d_gnt"}, {31'd0, dgn}, {31'd0, edg});
    chk({p, "_m_en"}, {31'd0, men}, {31'd0, efg | edg});
    chk({p, "_m_we"}, {31'd0, mwe}, {31'd0, ewe});
    chk({p, "_m_addr"}, madr, ea);
    chk({p, "_m_wdata"}, mwd, ew);
    chk({p, "_f_rvalid"}, {31'd0, frv}, {31'd0, efr});
    chk({p, "_d_rvalid"}, {31'd0, drv}, {31'd0, edr});
    if (quiet) begin
      chk({p, "_f_rdata_rst"}, frd, 32'd0);
      chk({p, "_d_rdata_rst"}, drd, 32'd0);
    end
    if (efr) chk({p, "_f_rdata"}, frd, edat);
    if (edr) chk({p, "_d_rdata"}, drd, edat);
  endtask

  task automatic do_cycle();
    bit          quiet, fe, de, fg, dg;
    bit          efr [2];
    bit          edr [2];
    logic [31:0] edat [2];
    logic [31:0] ea, ew;
    int          s, t;
    @(negedge clk);
    quiet = rst || rst_prev;
    fe = f_req && !c_flush && !quiet;
    de = d_req && !quiet;
`ifdef ARB_RR_EN
    if (fe && de) begin
      fg = last_lsu;
      dg = !last_lsu;
    end else begin
      fg = fe;
      dg = de;
    end
`else
    dg = de;
    fg = fe && !de;
`endif
    ea = dg ? d_addr : (fg ? f_addr : 32'd0);
    ew = dg ? d_wdata : 32'd0;
    s = cyc % 8;
    for (int k = 0; k < 2; k++) begin
      efr[k] = 1'b0;
      edr[k] = 1'b0;
      edat[k] = pd[k][s];
      if (!quiet && pv[k][s]) begin
        if (po[k][s]) edr[k] = 1'b1;
        else          efr[k] = !c_flush;
      end
    end
    check_dut("lat1", f_gnt1, d_gnt1, m_en1, m_we1, m_addr1, m_wdata1, f_rvalid1, d_rvalid1,
              f_rdata1, d_rdata1, fg, dg, ea, ew, dg && d_we, efr[0], edr[0], edat[0], quiet);
    check_dut("lat2", f_gnt2, d_gnt2, m_en2, m_we2, m_addr2, m_wdata2, f_rvalid2, d_rvalid2,
              f_rdata2, d_rdata2, fg, dg, ea, ew, dg && d_we, efr[1], edr[1], edat[1], quiet);
    for (int k = 0; k < 2; k++) begin
      pv[k][s] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (rst) pv[k][j] = 1'b0;
        if (c_flush && !po[k][j]) pv[k][j] = 1'b0;
      end
    end
    if (fg || (dg && !d_we)) begin
      for (int k = 0; k < 2; k++) begin
        t = (cyc + k + 1) % 8;
        pv[k][t] = 1'b1;
        po[k][t] = dg;
        pd[k][t] = gold[ea[7:0]];
      end
    end
    if (fg) $display("txn cyc=%0d FETCH read addr=%02h", cyc, ea[7:0]);
    if (dg && d_we) $display("txn cyc=%0d LSU write addr=%02h data=%h", cyc, ea[7:0], ew);
    if (dg && !d_we) $display("txn cyc=%0d LSU read addr=%02h", cyc, ea[7:0]);
    if (dg && d_we) gold[d_addr[7:0]] = d_wdata;
    if (fg) last_lsu = 1'b0;
    if (dg) last_lsu = 1'b1;
    if (rst) last_lsu = 1'b1;
    rst_prev = rst;
    last_fg = fg;
    last_dg = dg;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic fl, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] dd);
    rst = r; c_flush = fl; f_req = fr; f_addr = fa;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    do_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) gold[i] = init_val(i);
    for (int k = 0; k < 2; k++) for (int j = 0; j < 8; j++) begin
      pv[k][j] = 1'b0; po[k][j] = 1'b0; pd[k][j] = 32'd0;
    end
    init_mem = 1'b1;
    rst = 1'b1; c_flush = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    #1;
    init_mem = 1'b0;
    // reset with requests asserted, then the quiet cycle after reset
    step(1, 0, 1, 32'h05, 1, 1, 32'h06, 32'h7);
    step(1, 0, 1, 32'h05, 1, 0, 32'h06, 32'h0);
    step(0, 0, 1, 32'h10, 1, 0, 32'h44, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    // single fetch read of 0x10
    step(0, 0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    // write then read back
    step(0, 0, 0, 32'h0, 1, 1, 32'h20, 32'h12345678);
    step(0, 0, 0, 32'h0, 1, 0, 32'h20, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    // contention
    repeat (3) step(0, 0, 1, 32'h30, 1, 0, 32'h40, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    // flush one cycle after a fetch grant, LSU read granted in the flush cycle
    step(0, 0, 1, 32'h11, 0, 0, 32'h0, 32'h0);
    step(0, 1, 1, 32'h12, 1, 0, 32'h41, 32'h0);
    repeat (3) step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    // reset one cycle after a fetch grant
    step(0, 0, 1, 32'h13, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (3) step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    // randomized traffic; requesters hold until granted
    for (int n = 0; n < 400; n++) begin
      logic fr, dr, dw, r, fl;
      logic [31:0] fa, da, dd;
      fr = f_req; fa = f_addr; dr = d_req; dw = d_we; da = d_addr; dd = d_wdata;
      if (!(f_req && !last_fg) || rst) begin
        fr = ($urandom_range(0, 3) != 0);
        fa = {24'd0, 8'($urandom_range(0, 255))};
      end
      if (!(d_req && !last_dg) || rst) begin
        dr = ($urandom_range(0, 2) != 0);
        dw = $urandom_range(0, 1) != 0;
        da = {24'd0, 8'($urandom_range(0, 255))};
        dd = $urandom;
      end
      r  = ($urandom_range(0, 79) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(r, fl, fr, fa, dr, dw, da, dd);
    end
    repeat (3) step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
